// File: rtl/coef_mem_arbiter_pkg.sv
// Shared constants and types for the coefficient-BRAM round-robin arbiter.
// Holds the requester indices, the read encoding of the byte enables and the word width.
package coef_mem_arbiter_pkg;

    localparam int unsigned NREQ_DEF = 3;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned WE_W     = 8;

    // Fixed requester slots on the coefficient port
    localparam int unsigned REQ_CU   = 0;
    localparam int unsigned REQ_BP   = 1;
    localparam int unsigned REQ_HOST = 2;

    localparam logic [WE_W-1:0] WE_READ = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Index reached by stepping 'off' places past 'base' around a ring of 'n' slots
    function automatic int unsigned rr_wrap(int unsigned base, int unsigned off, int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/coef_mem_arbiter_if.sv
// Requester-side and memory-side signals of the coefficient BRAM arbiter.
// slave = arbiter view; master = requesters plus the BRAM itself.
interface coef_mem_arbiter_if
    import coef_mem_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned A    = ADDR_W,
    parameter int unsigned N    = DATA_W
);

    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ*A-1:0]    addr;
    logic [NREQ*WE_W-1:0] we;
    logic [NREQ*N-1:0]    wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [N-1:0]         rdata;

    logic                 mem_en;
    logic [A-1:0]         mem_addr;
    logic [WE_W-1:0]      mem_we;
    logic [N-1:0]         mem_din;
    logic [N-1:0]         mem_dout;

    modport slave (
        input  req, lock, addr, we, wdata, mem_dout,
        output gnt, rvalid, rdata, mem_en, mem_addr, mem_we, mem_din
    );

    modport master (
        output req, lock, addr, we, wdata, mem_dout,
        input  gnt, rvalid, rdata, mem_en, mem_addr, mem_we, mem_din
    );

endinterface

// File: rtl/coef_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after ptr, wrapping back to ptr.
// Returns the winner both one-hot and as an index.
module coef_mem_arbiter_rr_pick
    import coef_mem_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick_c,
    output logic [PW-1:0]   idx_c,
    output logic            valid_c
);

    always_comb begin
        pick_c  = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        // ptr itself is visited last, so the previous winner has lowest priority
        for (int unsigned off = 1; off <= NREQ; off++) begin
            if (!valid_c && req[PW'(rr_wrap(32'(ptr), off, NREQ))]) begin
                pick_c[PW'(rr_wrap(32'(ptr), off, NREQ))] = 1'b1;
                idx_c   = PW'(rr_wrap(32'(ptr), off, NREQ));
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coef_mem_arbiter.sv
// Round-robin arbiter sharing the single-port coefficient BRAM between NREQ requesters.
// Define ARB_TIMEOUT_EN to bound how long a locked owner may hold the port (MAX_HOLD cycles).
module coef_mem_arbiter
    import coef_mem_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned A    = ADDR_W,
    parameter int unsigned N    = DATA_W
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned MAX_HOLD = 64
`endif
) (
    input  logic               clk,
    input  logic               rst,
    coef_mem_arbiter_if.slave  bus
);

    localparam int unsigned PW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] pick_c;
    logic [PW-1:0]   pick_idx_c;
    logic            pick_valid_c;

    logic            own_c;
    logic            own_req_c;
    logic            own_lock_c;
    logic            force_c;
    logic            keep_c;
    logic            mem_en_c;
    logic            rd_c;

    logic [A-1:0]    addr_a  [NREQ];
    logic [WE_W-1:0] we_a    [NREQ];
    logic [N-1:0]    wdata_a [NREQ];
    logic [A-1:0]    own_addr_c;
    logic [WE_W-1:0] own_we_c;
    logic [N-1:0]    own_wdata_c;

    // Unpack per-requester fields so the owner can be selected by index
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = bus.addr[i*A +: A];
        assign we_a[i]    = bus.we[i*WE_W +: WE_W];
        assign wdata_a[i] = bus.wdata[i*N +: N];
    end

    coef_mem_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .pick_c  (pick_c),
        .idx_c   (pick_idx_c),
        .valid_c (pick_valid_c)
    );

    // While owning, ptr_q always holds the owner index
    assign own_c       = (state_q == ST_OWN);
    assign own_req_c   = own_c && bus.req[ptr_q];
    assign own_lock_c  = own_req_c && bus.lock[ptr_q];
    assign own_addr_c  = own_c ? addr_a[ptr_q]  : '0;
    assign own_we_c    = own_c ? we_a[ptr_q]    : WE_READ;
    assign own_wdata_c = own_c ? wdata_a[ptr_q] : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_q, hold_d;
    logic          others_c;

    assign others_c = |(bus.req & ~gnt_q);
    // hold_q counts earlier locked cycles; this cycle is the MAX_HOLD-th when it reaches MAX_HOLD-1
    assign force_c  = own_lock_c && others_c && (hold_q == CW'(MAX_HOLD - 1));
    assign hold_d   = !keep_c ? '0 :
                      (hold_q == CW'(MAX_HOLD - 1)) ? hold_q : hold_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign force_c = 1'b0;
`endif

    assign keep_c = own_lock_c && !force_c;

    // Memory access happens in the granted cycle; nothing reaches the BRAM during reset
    assign mem_en_c = own_req_c && !rst;
    assign rd_c     = mem_en_c && (own_we_c == WE_READ);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        rvalid_d = '0;
        if (rd_c) begin
            rvalid_d = gnt_q;
        end
        if (!keep_c) begin
            if (pick_valid_c) begin
                state_d = ST_OWN;
                gnt_d   = pick_c;
                ptr_d   = pick_idx_c;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ptr_q    <= PW'(NREQ - 1);
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = bus.mem_dout;
    assign bus.mem_en   = mem_en_c;
    assign bus.mem_addr = own_addr_c;
    assign bus.mem_we   = mem_en_c ? own_we_c : WE_READ;
    assign bus.mem_din  = own_wdata_c;

endmodule

// File: tb/tb_coef_mem_arbiter.sv
// Self-checking bench for coef_mem_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules and BRAM contents.
module tb_coef_mem_arbiter;
    import coef_mem_arbiter_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned A    = 8;
    localparam int unsigned N    = 16;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned MAX_HOLD = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coef_mem_arbiter_if #(.NREQ(NREQ), .A(A), .N(N)) bus ();

`ifdef ARB_TIMEOUT_EN
    coef_mem_arbiter #(.NREQ(NREQ), .A(A), .N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    coef_mem_arbiter #(.NREQ(NREQ), .A(A), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    int errors = 0;
    int checks = 0;

    function automatic logic [N-1:0] init_val(logic [A-1:0] a);
        return (a == 8'h05) ? 16'h0A3C : ((16'(a) * 16'd37) ^ 16'hC3A5);
    endfunction

    // BRAM: one-cycle read latency, byte-enabled writes, contents start at init_val()
    logic [N-1:0] mem    [256];
    bit           mem_wr [256];
    initial bus.mem_dout = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we == 8'h00) begin
                bus.mem_dout <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
            end else begin
                mem[bus.mem_addr] <= {
                    bus.mem_we[1] ? bus.mem_din[15:8] :
                        (mem_wr[bus.mem_addr] ? mem[bus.mem_addr][15:8] : init_val(bus.mem_addr)[15:8]),
                    bus.mem_we[0] ? bus.mem_din[7:0] :
                        (mem_wr[bus.mem_addr] ? mem[bus.mem_addr][7:0] : init_val(bus.mem_addr)[7:0])};
                mem_wr[bus.mem_addr] <= 1'b1;
            end
        end
    end

    // Reference model state: owner (-1 = none), last winner, locked-run length, expected contents
    int           m_own  = -1;
    int           m_ptr  = NREQ - 1;
    int           m_run  = 0;
    bit           m_init = 1'b0;
    logic [N-1:0] ref_mem [256];
    bit           ref_wr  [256];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(int i, bit r, bit l, logic [7:0] w, logic [A-1:0] a, logic [N-1:0] d);
        bus.req[i]           = r;
        bus.lock[i]          = l;
        bus.we[i*8 +: 8]     = w;
        bus.addr[i*A +: A]   = a;
        bus.wdata[i*N +: N]  = d;
    endtask

    // One clock: check the access mux mid-cycle, advance the model, check registered outputs after the edge
    task automatic cycle();
        bit              was_rst;
        bit              exp_en;
        bit              force_out;
        logic [7:0]      own_we;
        logic [7:0]      exp_we;
        logic [A-1:0]    exp_addr;
        logic [N-1:0]    exp_din;
        logic [N-1:0]    cur;
        logic [NREQ-1:0] others;
        logic [NREQ-1:0] exp_rvalid;
        logic [N-1:0]    exp_rdata;
        int              run_cur;
        int              nxt;
        int              idx;

        @(negedge clk);
        was_rst    = rst;
        exp_rvalid = '0;
        exp_rdata  = '0;
        exp_en     = (rst == 1'b0) && (m_own >= 0) && (bus.req[m_own] == 1'b1);
        if (m_own >= 0) begin
            exp_addr = bus.addr[m_own*A +: A];
            exp_din  = bus.wdata[m_own*N +: N];
            own_we   = bus.we[m_own*8 +: 8];
        end else begin
            exp_addr = '0;
            exp_din  = '0;
            own_we   = '0;
        end
        exp_we = exp_en ? own_we : 8'h00;
        if (m_init) begin
            check("mem_en",   32'(bus.mem_en),   32'(exp_en));
            check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
            check("mem_we",   32'(bus.mem_we),   32'(exp_we));
            check("mem_din",  32'(bus.mem_din),  32'(exp_din));
        end

        if (rst) begin
            m_own = -1;
            m_ptr = NREQ - 1;
            m_run = 0;
        end else begin
            cur = ref_wr[exp_addr] ? ref_mem[exp_addr] : init_val(exp_addr);
            if (exp_en && exp_we == 8'h00) begin
                exp_rvalid[m_own] = 1'b1;
                exp_rdata         = cur;
            end else if (exp_en) begin
                if (exp_we[0]) cur[7:0]  = exp_din[7:0];
                if (exp_we[1]) cur[15:8] = exp_din[15:8];
                ref_mem[exp_addr] = cur;
                ref_wr[exp_addr]  = 1'b1;
            end
            run_cur = (m_own >= 0 && bus.req[m_own] && bus.lock[m_own]) ? m_run + 1 : 0;
            others  = bus.req;
            if (m_own >= 0) others[m_own] = 1'b0;
            force_out = 1'b0;
`ifdef ARB_TIMEOUT_EN
            force_out = (run_cur >= int'(MAX_HOLD)) && (others != '0);
`endif
            if (run_cur > 0 && !force_out) begin
                m_run = run_cur;
            end else begin
                m_run = 0;
                nxt   = -1;
                for (int k = 1; k <= int'(NREQ); k++) begin
                    idx = (m_ptr + k) % int'(NREQ);
                    if (nxt < 0 && bus.req[idx]) nxt = idx;
                end
                m_own = nxt;
                if (nxt >= 0) m_ptr = nxt;
            end
        end

        @(posedge clk);
        #1;
        if (was_rst) m_init = 1'b1;
        if (m_init) begin
            check("gnt",    32'(bus.gnt),    (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
            check("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
            if (exp_rvalid != '0) check("rdata", 32'(bus.rdata), 32'(exp_rdata));
        end
    endtask

    task automatic idle(int n);
        bus.req  = '0;
        bus.lock = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] prev;
        logic [NREQ-1:0] rr_seq [6];
        int              saw2;
        int              first2;

        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        for (int i = 0; i < 256; i++) ref_wr[i] = 1'b0;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        check("reset_gnt",    32'(bus.gnt),      32'd0);
        check("reset_rvalid", 32'(bus.rvalid),   32'd0);
        check("reset_mem_en", 32'(bus.mem_en),   32'd0);
        check("reset_addr",   32'(bus.mem_addr), 32'd0);
        rst = 1'b0;

        // All three reading: grant rotates 0,1,2,0... with rvalid one clock behind
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;
        for (int i = 0; i < int'(NREQ); i++) drive(i, 1'b1, 1'b0, 8'h00, A'(i + 1), '0);
        prev = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_gnt",    32'(bus.gnt),    32'(rr_seq[i]));
            check("rr_rvalid", 32'(bus.rvalid), 32'(prev));
            prev = rr_seq[i];
        end
        idle(2);

        // Lone host reader is re-granted back to back
        drive(REQ_HOST, 1'b1, 1'b0, 8'h00, 8'h10, '0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("host_addr",   32'(bus.mem_addr), 32'h10);
            check("host_rvalid", 32'(bus.rvalid),   32'b100);
        end
        idle(2);

        // Preloaded word read by backprop
        drive(REQ_BP, 1'b1, 1'b0, 8'h00, 8'h05, '0);
        cycle();
        cycle();
        check("bp_rvalid", 32'(bus.rvalid), 32'b010);
        check("bp_rdata",  32'(bus.rdata),  32'h0A3C);
        idle(2);

        // Locked write burst from the control unit, backprop requests mid-burst
        drive(REQ_CU, 1'b1, 1'b1, 8'h03, 8'h20, 16'(N'($urandom)));
        cycle();
        for (int i = 0; i < 20; i++) begin
            drive(REQ_CU, 1'b1, 1'b1, 8'h03, A'(32'h20 + i), N'($urandom));
            if (i == 10) drive(REQ_BP, 1'b1, 1'b0, 8'h00, 8'h21, '0);
            cycle();
`ifndef ARB_TIMEOUT_EN
            check("burst_gnt", 32'(bus.gnt), 32'b001);
`endif
        end
        drive(REQ_CU, 1'b0, 1'b0, 8'h00, '0, '0);
        cycle();
        check("burst_handoff", 32'(bus.gnt), 32'b010);
        idle(2);

        // Reset while backprop owns the port with a read in flight
        drive(REQ_BP, 1'b1, 1'b0, 8'h00, 8'h03, '0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check("midrst_gnt",    32'(bus.gnt),    32'd0);
        check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) drive(i, 1'b1, 1'b0, 8'h00, A'(i), '0);
        cycle();
        check("postrst_gnt", 32'(bus.gnt), 32'b001);
        idle(2);

        // Control unit locks forever while host waits
        drive(REQ_CU, 1'b1, 1'b1, 8'h00, 8'h01, '0);
        cycle();
        drive(REQ_HOST, 1'b1, 1'b0, 8'h00, 8'h02, '0);
        saw2   = 0;
        first2 = -1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.gnt[REQ_HOST] === 1'b1) begin
                saw2++;
                if (first2 < 0) first2 = i;
            end
        end
`ifdef ARB_TIMEOUT_EN
        check("timeout_first_gnt2", 32'(first2), 32'd3);
`else
        check("lock_never_gnt2", 32'(saw2), 32'd0);
`endif
        idle(2);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < int'(NREQ); r++) begin
                drive(r, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                      A'($urandom_range(0, 15)), N'($urandom));
            end
            rst = ($urandom_range(0, 39) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
